// File: rtl/alu8_chk_pkg.sv
// Shared definitions for the 8-bit ALU response checkers.
// Holds the ALU function codes, the checker FSM state type, the golden
// response record and the golden-model function alu_golden.
// Optional feature macro used by checkers: ALU_CHECK_MISCAPTURE_EN.
package alu8_chk_pkg;

  // Width the golden function is written for; checkers use SIZE == AluW.
  localparam int unsigned AluW = 8;

  localparam logic [1:0] FN_ADD     = 2'b00;  // A + B + CI
  localparam logic [1:0] FN_ADDHALF = 2'b01;  // A + (B >> 1) + CI
  localparam logic [1:0] FN_AND     = 2'b10;  // A & B
  localparam logic [1:0] FN_NOT     = 2'b11;  // ~A

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } chk_state_e;

  typedef struct packed {
    logic [AluW-1:0] res;
    logic            co;
    logic            ov;
  } alu_resp_t;

  // Reference ALU response. Sum is formed one bit wider so the carry falls
  // out as the top bit; overflow is the classic same-sign-in, other-sign-out.
  function automatic alu_resp_t alu_golden(input logic [AluW-1:0] a,
                                           input logic [AluW-1:0] b,
                                           input logic [1:0]      fn,
                                           input logic            ci);
    alu_resp_t     r;
    logic [AluW-1:0] bop;
    logic [AluW:0]   s;
    r   = '0;
    bop = b;
    s   = '0;
    case (fn)
      FN_ADD, FN_ADDHALF: begin
        bop   = (fn == FN_ADDHALF) ? {1'b0, b[AluW-1:1]} : b;
        s     = {1'b0, a} + {1'b0, bop} + {{AluW{1'b0}}, ci};
        r.res = s[AluW-1:0];
        r.co  = s[AluW];
        r.ov  = (a[AluW-1] == bop[AluW-1]) & (s[AluW-1] != a[AluW-1]);
      end
      FN_AND:  r.res = a & b;
      default: r.res = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu8_golden_model.sv
// Combinational golden model of the 8-bit ALU, a thin wrapper around
// alu8_chk_pkg::alu_golden so other checkers can instantiate it.
// Ports:
//   a_i, b_i  operands
//   fn_i      function code (FN_ADD, FN_ADDHALF, FN_AND, FN_NOT)
//   ci_i      carry-in
//   res_o     expected result
//   co_o      expected carry-out
//   ov_o      expected signed overflow
module alu8_golden_model
  import alu8_chk_pkg::*;
(
  input  logic [AluW-1:0] a_i,
  input  logic [AluW-1:0] b_i,
  input  logic [1:0]      fn_i,
  input  logic            ci_i,
  output logic [AluW-1:0] res_o,
  output logic            co_o,
  output logic            ov_o
);

  alu_resp_t resp;

  always_comb begin
    resp = alu_golden(a_i, b_i, fn_i, ci_i);
  end

  assign res_o = resp.res;
  assign co_o  = resp.co;
  assign ov_o  = resp.ov;

endmodule

// File: rtl/alu8_response_checker.sv
// Self-checking response monitor for the 8-bit ALU. Each valid cycle it
// registers the applied vector plus the ALU response, recomputes the
// expected response one cycle later and counts matches/mismatches. A run
// is armed by Start for NumVec vectors and ends with a Done/Pass verdict.
// Optional macro ALU_CHECK_MISCAPTURE_EN adds a first-mismatch record.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Start, NumVec         arm a run for NumVec vectors (ignored while busy)
//   InValid, Ain, Bin,    applied vector, taken only while running
//   Fn, CI
//   Result, CO, OV        response returned by the ALU
//   Busy, Done, Pass      run status; Pass = Done with no failures
//   PassCount, FailCount  saturating compare counters for this run
//   ErrFlag               sticky, set on first mismatch
//   MisValid, MisIndex,   first mismatch: 0-based index, expected and
//   MisExp, MisGot        received Result (macro only)
module alu8_response_checker
  import alu8_chk_pkg::*;
#(
  parameter int unsigned SIZE  = AluW,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CNT_W-1:0] NumVec,
  input  logic             InValid,
  input  logic [SIZE-1:0]  Ain,
  input  logic [SIZE-1:0]  Bin,
  input  logic [1:0]       Fn,
  input  logic             CI,
  input  logic [SIZE-1:0]  Result,
  input  logic             CO,
  input  logic             OV,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] PassCount,
  output logic [CNT_W-1:0] FailCount,
`ifdef ALU_CHECK_MISCAPTURE_EN
  output logic             MisValid,
  output logic [CNT_W-1:0] MisIndex,
  output logic [SIZE-1:0]  MisExp,
  output logic [SIZE-1:0]  MisGot,
`endif
  output logic             ErrFlag
);

  chk_state_e       state_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] num_vec_q, acc_q, acc_inc;

  logic             start_go, accept;

  // Stage 1: registered vector and response
  logic             s1_valid_q;
  logic [SIZE-1:0]  s1_a_q, s1_b_q, s1_res_q;
  logic [1:0]       s1_fn_q;
  logic             s1_ci_q, s1_co_q, s1_ov_q;

  // Stage 2: golden response and compare
  logic [SIZE-1:0]  gold_res;
  logic             gold_co, gold_ov, match;

  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic             err_q;

  // Start is honoured only when no run is in flight.
  assign start_go = Start && ((state_q == StIdle) || (state_q == StDone));
  assign accept   = InValid && (state_q == StRun);
  assign acc_inc  = acc_q + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      num_vec_q <= '0;
      acc_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            num_vec_q <= NumVec;
            acc_q     <= '0;
            if (NumVec == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (InValid) begin
            acc_q <= acc_inc;
            if (acc_inc == num_vec_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Last vector retires in stage 2 on this edge.
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_CHECK_MISCAPTURE_EN
  logic [CNT_W-1:0] s1_idx_q;
  logic             mis_valid_q;
  logic [CNT_W-1:0] mis_idx_q;
  logic [SIZE-1:0]  mis_exp_q, mis_got_q;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_fn_q    <= '0;
      s1_ci_q    <= 1'b0;
      s1_res_q   <= '0;
      s1_co_q    <= 1'b0;
      s1_ov_q    <= 1'b0;
`ifdef ALU_CHECK_MISCAPTURE_EN
      s1_idx_q   <= '0;
`endif
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q   <= Ain;
        s1_b_q   <= Bin;
        s1_fn_q  <= Fn;
        s1_ci_q  <= CI;
        s1_res_q <= Result;
        s1_co_q  <= CO;
        s1_ov_q  <= OV;
`ifdef ALU_CHECK_MISCAPTURE_EN
        s1_idx_q <= acc_q;
`endif
      end
    end
  end

  alu8_golden_model u_golden (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .fn_i  (s1_fn_q),
    .ci_i  (s1_ci_q),
    .res_o (gold_res),
    .co_o  (gold_co),
    .ov_o  (gold_ov)
  );

  assign match = ({s1_res_q, s1_co_q, s1_ov_q} == {gold_res, gold_co, gold_ov});

  always_ff @(posedge Clk) begin
    if (Reset || start_go) begin
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_q       <= 1'b0;
`ifdef ALU_CHECK_MISCAPTURE_EN
      mis_valid_q <= 1'b0;
      mis_idx_q   <= '0;
      mis_exp_q   <= '0;
      mis_got_q   <= '0;
`endif
    end else if (s1_valid_q) begin
      if (match) begin
        if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
        err_q <= 1'b1;
`ifdef ALU_CHECK_MISCAPTURE_EN
        if (!mis_valid_q) begin
          mis_valid_q <= 1'b1;
          mis_idx_q   <= s1_idx_q;
          mis_exp_q   <= gold_res;
          mis_got_q   <= s1_res_q;
        end
`endif
      end
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = done_q && (fail_cnt_q == '0);
  assign PassCount = pass_cnt_q;
  assign FailCount = fail_cnt_q;
  assign ErrFlag   = err_q;
`ifdef ALU_CHECK_MISCAPTURE_EN
  assign MisValid  = mis_valid_q;
  assign MisIndex  = mis_idx_q;
  assign MisExp    = mis_exp_q;
  assign MisGot    = mis_got_q;
`endif

endmodule
